// File: rtl/ram_burst_reader.sv
// Burst read initiator: walks a contiguous RAM address range and streams each
// word out on a valid/ready interface, flagging the final beat with out_last.
//
// state  | meaning
// IDLE   | waiting for start; outputs quiet
// READ   | mem_rd asserted, RAM data captured into out_data at the edge
// HOLD   | beat presented, waiting for out_ready
// FIN    | one-cycle done pulse, then back to IDLE
module ram_burst_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_HOLD, S_FIN} state_t;

  localparam logic [ADDR_W:0] REM_ONE = 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [ADDR_W:0]   remaining, remaining_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic              valid_q, valid_nxt;
  logic              last_q, last_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      remaining <= remaining_nxt;
      data_q    <= data_nxt;
      valid_q   <= valid_nxt;
      last_q    <= last_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    remaining_nxt = remaining;
    data_nxt      = data_q;
    valid_nxt     = valid_q;
    last_nxt      = last_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            addr_nxt      = base_addr;
            remaining_nxt = length;
            state_nxt     = S_READ;
          end else begin
            state_nxt = S_FIN;
          end
        end
      end
      S_READ: begin
        data_nxt  = mem_data;
        valid_nxt = 1'b1;
        last_nxt  = (remaining == REM_ONE);
        state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (valid_q && out_ready) begin
          valid_nxt     = 1'b0;
          last_nxt      = 1'b0;
          remaining_nxt = remaining - 1'b1;
          if (remaining == REM_ONE) begin
            state_nxt = S_FIN;
          end else begin
            addr_nxt  = addr + 1'b1;
            state_nxt = S_READ;
          end
        end
      end
      S_FIN: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // abort wins over any handshake on the same edge
    if (abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      valid_nxt = 1'b0;
      last_nxt  = 1'b0;
    end
  end

  assign mem_rd    = (state == S_READ);
  assign mem_addr  = addr;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FIN);

endmodule
